sext_request_arbiter: RTL and testbench
=======================================

Name: sext_request_arbiter

Overview:
- Shares one registered 10-to-16-bit immediate extension stage between NUM_REQ requesters, e.g. decode immediate path, branch-offset path and load/store offset path.
- Sits between the decode stage and the ALU/address operand muxes.
- Round-robin arbitration, a valid/ready handshake on each requester side, and a single valid/ready response channel tagged with the requester ID.

Parameters:
- NUM_REQ, 2: number of requesters. Legal range 2..4.
- IN_W, 10: immediate field width. Sign bit is bit IN_W-1.
- OUT_W, 16: extended result width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot grant; asserted for exactly the accept cycle.
- req_data  in  NUM_REQ*IN_W  packed immediates; requester i occupies bits [i*IN_W +: IN_W].
- req_zext  in  NUM_REQ  per requester: 1 = zero-extend, 0 = sign-extend.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  2  index of the requester that owns rsp_data.
- rsp_data  out  OUT_W  extended immediate.
- stat_cnt  out  NUM_REQ*16  per-requester grant counters (see Optional Feature).

Behaviour:
- Reset (asynchronous, immediate on rst=1):
  - FSM = IDLE.
  - req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0.
  - Round-robin pointer = 0, so requester 0 has highest priority first.
- FSM states and transitions:
  - IDLE: if any req_valid is high, grant the first set bit searching from the pointer upward with wrap. Assert req_ready for the winner combinationally in this cycle. Capture the winner's data, zext flag and ID into the extension stage. Go to EXT. If no request, stay in IDLE.
  - EXT: the extension stage register updates on this edge. Go to HOLD, asserting rsp_valid from the next cycle.
  - HOLD: rsp_valid = 1, with rsp_id/rsp_data stable. If rsp_ready = 1, drop rsp_valid on the next edge, set pointer = winner+1 (mod NUM_REQ), and go to IDLE. Otherwise stay in HOLD with outputs frozen.
- Timing:
  - Latency from accept to first rsp_valid is 2 cycles.
  - Peak throughput is one result per 3 cycles (IDLE/EXT/HOLD).
  - No overlap: a new grant is never issued while HOLD is pending.
- Extension rules:
  - zext = 1: upper OUT_W-IN_W bits are 0.
  - zext = 0: upper bits replicate data[IN_W-1]. Bit 9 is the sign bit, not bit 8.
  - Result width is exactly OUT_W; no truncation of the input.
- Handshake rules:
  - A requester must hold req_valid/req_data/req_zext until it sees req_ready.
  - Dropping req_valid before the grant is legal; the request is simply not served.
  - req_ready is never asserted to a requester whose req_valid is low.
- Boundary conditions:
  - Simultaneous requests: only one grant per IDLE cycle. Others wait; the pointer guarantees each waiting requester is served within NUM_REQ grants.
  - Same requester re-requesting on the cycle after its result completes: it gets the lowest priority.
  - rst during EXT/HOLD: the in-flight result is discarded, rsp_valid drops immediately, and the pointer returns to 0.
  - rsp_ready high while rsp_valid is low: ignored.
  - rsp_id for unused index bits (NUM_REQ=2): the upper bit is 0.

Optional Feature:
- Macro SEXT_ARB_STATS_EN.
- Defined: each requester has a 16-bit grant counter. It increments on every grant, saturates at 16'hFFFF, is cleared by rst, and drives stat_cnt.
- Undefined: no counter logic is synthesised and stat_cnt is tied to 0.
- Arbitration and timing are identical in both builds.

Decomposition:
- Package sext_arb_pkg:
  - IN_W/OUT_W defaults.
  - State enum {IDLE, EXT, HOLD}.
  - Requester-ID typedef (2 bits).
  - Saturation constant 16'hFFFF.
- Sub-module sext_stage:
  - Registered extender with data_in[IN_W-1:0], zext and load enable; output data_out[OUT_W-1:0].
  - Holds its value when load = 0.
  - Reset value 0, using the same clk/rst.

Test Plan:
- Single request: req0 valid with data 10'h200, zext=0 → req_ready[0] in the same cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_data=16'hFE00.
- Zero-extend and bit-8 check: data 10'h100 with zext=0 → 16'h0100; data 10'h3FF with zext=1 → 16'h03FF.
- Contention: both valid every cycle, rsp_ready tied 1 → grant order 0,1,0,1…, one result per 3 cycles, no requester starved.
- Backpressure: hold rsp_ready=0 for 5 cycles in HOLD → rsp_valid/rsp_data stay stable, no new req_ready; the release cycle returns the FSM to IDLE.
- Mid-operation reset: assert rst while in EXT → all outputs are 0 immediately; after release, a new req1 (10'h00C, zext=0) yields rsp_data=16'h000C, rsp_id=1.
- Stats build (SEXT_ARB_STATS_EN): 3 grants to req0 and 1 to req1 → stat_cnt fields = 3 and 1. In the non-stats build, stat_cnt = 0.

Source files
------------

// File: rtl/sext_request_arbiter_pkg.sv
// sext_arb_pkg: shared widths, FSM state, requester ID type and counter limit for the extension arbiter
package sext_arb_pkg;
    localparam int IN_W_DEF = 10;
    localparam int OUT_W_DEF = 16;
    typedef enum logic [1:0] {IDLE, EXT, HOLD} state_t;
    typedef logic [1:0] id_t;
    localparam logic [15:0] CNT_MAX = 16'hFFFF;
endpackage

// File: rtl/sext_stage.sv
// sext_stage: registered zero/sign extender that holds its value while load is low
module sext_stage
    import sext_arb_pkg::*;
#(
    parameter int IN_W = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             zext,
    input  logic [IN_W-1:0]  data_in,
    output logic [OUT_W-1:0] data_out
);
    logic [OUT_W-1:0] ext;
    assign ext = zext ? OUT_W'(data_in) : {{(OUT_W-IN_W){data_in[IN_W-1]}}, data_in};
    always_ff @(posedge clk or posedge rst)
        if (rst) data_out <= '0;
        else if (load) data_out <= ext;
endmodule

// File: rtl/sext_request_arbiter.sv
// sext_request_arbiter: round-robin share of one registered immediate extender among NUM_REQ requesters
// Per-requester grant counters on stat_cnt are built only when SEXT_ARB_STATS_EN is defined.
module sext_request_arbiter
    import sext_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IN_W = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*IN_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]      req_zext,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output id_t                     rsp_id,
    output logic [OUT_W-1:0]        rsp_data,
    output logic [NUM_REQ*16-1:0]   stat_cnt
);
    state_t state;
    id_t ptr, gnt_id;
    logic found, cap_zext;
    logic [IN_W-1:0] cap_data;
    logic [NUM_REQ-1:0] sel;
    int idx;
    // first valid requester at or above the pointer, wrapping around
    always_comb begin
        found = 1'b0;
        gnt_id = '0;
        idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && |(req_valid & (NUM_REQ'(1) << idx))) begin
                found = 1'b1;
                gnt_id = id_t'(idx);
            end
        end
    end
    assign sel = NUM_REQ'(1) << gnt_id;
    assign req_ready = (found && state == IDLE && !rst) ? sel : '0;
    assign rsp_valid = state == HOLD;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            ptr <= '0;
            rsp_id <= '0;
            cap_data <= '0;
            cap_zext <= 1'b0;
        end else if (state == IDLE && found) begin
            state <= EXT;
            rsp_id <= gnt_id;
            cap_data <= IN_W'(req_data >> (gnt_id * IN_W));
            cap_zext <= |(req_zext & sel);
        end else if (state == EXT) begin
            state <= HOLD;
        end else if (state == HOLD && rsp_ready) begin
            state <= IDLE;
            ptr <= (rsp_id == id_t'(NUM_REQ - 1)) ? '0 : rsp_id + 1'b1;
        end
    sext_stage #(.IN_W(IN_W), .OUT_W(OUT_W)) u_stage (
        .clk(clk),
        .rst(rst),
        .load(state == EXT),
        .zext(cap_zext),
        .data_in(cap_data),
        .data_out(rsp_data)
    );
`ifdef SEXT_ARB_STATS_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        logic [15:0] cnt;
        always_ff @(posedge clk or posedge rst)
            if (rst) cnt <= '0;
            else if (req_ready[g] && cnt != CNT_MAX) cnt <= cnt + 1'b1;
        assign stat_cnt[g*16 +: 16] = cnt;
    end
`else
    assign stat_cnt = '0;
`endif
endmodule

// File: tb/tb_sext_request_arbiter.sv
// tb_sext_request_arbiter: directed checks of grants, extension, backpressure, reset and stats
module tb_sext_request_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] req_valid = '0;
    logic [1:0] req_zext = '0;
    logic [1:0] req_ready;
    logic [19:0] req_data = '0;
    logic rsp_valid;
    logic rsp_ready = 1'b0;
    logic [1:0] rsp_id;
    logic [15:0] rsp_data;
    logic [31:0] stat_cnt;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sext_request_arbiter #(.NUM_REQ(2), .IN_W(10), .OUT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_data(req_data),
        .req_zext(req_zext),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id(rsp_id),
        .rsp_data(rsp_data),
        .stat_cnt(stat_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input logic [1:0] v, input logic [1:0] id, input logic [15:0] d);
        req_valid = v;
        rsp_ready = 1'b1;
        #1;
        chk("grant", 32'(req_ready), 32'(2'b01 << id));
        step;
        chk("ext_ready", 32'(req_ready), 0);
        chk("ext_valid", 32'(rsp_valid), 0);
        step;
        chk("hold_valid", 32'(rsp_valid), 1);
        chk("hold_id", 32'(rsp_id), 32'(id));
        chk("hold_data", 32'(rsp_data), 32'(d));
        step;
        chk("done_valid", 32'(rsp_valid), 0);
    endtask

    initial begin
        step;
        req_valid = 2'b01;
        #1;
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_id", 32'(rsp_id), 0);
        chk("rst_data", 32'(rsp_data), 0);
        chk("rst_stat", stat_cnt, 0);
        req_valid = '0;
        rst = 1'b0;
        step;
        // single requests: sign bit 9, bit 8 not a sign bit, zero-extend
        req_data[9:0] = 10'h200;
        req_zext = 2'b00;
        txn(2'b01, 2'd0, 16'hFE00);
        req_data[9:0] = 10'h100;
        txn(2'b01, 2'd0, 16'h0100);
        req_data[19:10] = 10'h3FF;
        req_zext = 2'b10;
        txn(2'b10, 2'd1, 16'h03FF);
        // contention alternates 0,1,0 back to back
        req_data = {10'h2AA, 10'h155};
        req_zext = 2'b00;
        txn(2'b11, 2'd0, 16'h0155);
        txn(2'b11, 2'd1, 16'hFEAA);
        txn(2'b11, 2'd0, 16'h0155);
        // backpressure on requester 1
        req_data[19:10] = 10'h3FF;
        req_valid = 2'b11;
        rsp_ready = 1'b0;
        #1;
        chk("bp_grant", 32'(req_ready), 32'h2);
        step;
        step;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(rsp_valid), 1);
            chk("bp_data", 32'(rsp_data), 32'hFFFF);
            chk("bp_ready", 32'(req_ready), 0);
            step;
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_rel_valid", 32'(rsp_valid), 1);
        step;
        chk("bp_idle_valid", 32'(rsp_valid), 0);
        chk("bp_next_grant", 32'(req_ready), 32'h1);
        req_valid = '0;
        #1;
        chk("drop_ready", 32'(req_ready), 0);
        step;
        chk("drop_valid", 32'(rsp_valid), 0);
        chk("drop_idle_ready", 32'(req_ready), 0);
`ifdef SEXT_ARB_STATS_EN
        chk("stat_pre", stat_cnt, {16'd3, 16'd4});
`else
        chk("stat_pre", stat_cnt, 0);
`endif
        // reset while the stage is in EXT
        req_data[9:0] = 10'h123;
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        step;
        req_valid = '0;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 0);
        chk("mid_rst_data", 32'(rsp_data), 0);
        chk("mid_rst_id", 32'(rsp_id), 0);
        chk("mid_rst_stat", stat_cnt, 0);
        step;
        rst = 1'b0;
        step;
        chk("post_rst_valid", 32'(rsp_valid), 0);
        req_data[19:10] = 10'h00C;
        req_zext = 2'b00;
        txn(2'b10, 2'd1, 16'h000C);
`ifdef SEXT_ARB_STATS_EN
        chk("stat_post", stat_cnt, {16'd1, 16'd0});
`else
        chk("stat_post", stat_cnt, 0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
